dxc_cap_sel_ctrl: RTL
=====================

DXC_CAP_SEL_CTRL -- requirements
Module: dxc_cap_sel_ctrl

Interface
REQ-001 SHALL have parameter NUM_LANES, default 8: number of parallel sample lanes on the sink bus.
REQ-002 SHALL have parameter DATA_W, default 32: bits per lane sample.
REQ-003 SHALL have parameter CH_W, default 8: width of the sink/source channel field.
REQ-004 SHALL have parameter LEN_W, default 16: width of the capture length and beat counter.
REQ-005 SHALL have derived localparam LANE_W = max(1, clog2(NUM_LANES)).
REQ-006 SHALL have the following ports (name  direction  width  meaning):
- dsp_in_clk_clk  in  1  sole clock; one clock, all logic on the rising edge.
- dsp_in_reset_reset  in  1  synchronous, active-high reset.
- sink_valid  in  1  beat valid; no backpressure.
- sink_channel  in  CH_W  channel tag of the beat.
- sink_data  in  NUM_LANES*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
- rfp_pulse  in  1  radio-frame pulse, single cycle.
- sel_data  in  32  control word: [7:0] lane, [8] rfp_align, [9] continuous, [30] abort (level), [31] start (edge).
- cap_len  in  LEN_W  beats per capture.
- src_valid  out  1  captured beat valid.
- src_data  out  DATA_W  selected lane sample.
- src_channel  out  CH_W  registered sink_channel.
- src_lane  out  LANE_W  latched lane index.
- src_sop  out  1  first beat of a capture.
- src_eop  out  1  last beat of a capture.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse at capture completion.
- err  out  1  sticky flag for a rejected start.

Function
REQ-007 SHALL implement the FSM states IDLE, ARMED, CAPTURE and DONE.
REQ-008 SHALL detect start as a rising edge of sel_data[31], registered against its previous-cycle value.
REQ-009 In IDLE, a start with lane < NUM_LANES and cap_len != 0 SHALL latch lane, cap_len, rfp_align and continuous, then go to ARMED if rfp_align=1, else to CAPTURE.
REQ-010 In IDLE, a start with lane >= NUM_LANES or cap_len == 0 SHALL set err and remain in IDLE.
REQ-011 A start edge seen in any state other than IDLE SHALL be ignored, and SHALL NOT set err.
REQ-012 ARMED SHALL go to CAPTURE on the cycle after rfp_pulse=1; sink beats arriving in the same cycle as rfp_pulse SHALL NOT be captured.
REQ-013 In CAPTURE, each sink_valid beat SHALL produce one output beat exactly 1 cycle later: src_valid=1, src_data = latched lane slice, src_channel = sink_channel, src_lane = latched lane.
REQ-014 Cycles with sink_valid=0 SHALL produce src_valid=0 and SHALL NOT advance the beat counter.
REQ-015 src_sop SHALL be 1 on beat 0 of each capture, and src_eop SHALL be 1 on beat cap_len-1; when cap_len=1, both SHALL be 1 on the same beat.
REQ-016 After the last beat is accepted, the FSM SHALL go to DONE if continuous=0; if continuous=1, it SHALL reset the counter and go to ARMED (rfp_align=1) or stay in CAPTURE (rfp_align=0).
REQ-017 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-018 rfp_pulse SHALL be ignored outside ARMED.
REQ-019 The counter SHALL be LEN_W bits, compare against the latched cap_len only, and never wrap within a capture.
REQ-020 sel_data[30]=1 SHALL force IDLE on the next cycle from any state; the next-cycle src_valid/src_sop/src_eop SHALL be 0, no done SHALL be issued, and abort SHALL take priority over a simultaneous start or last beat.
REQ-021 Changes to sel_data fields or cap_len outside IDLE SHALL have no effect until the next accepted start.
REQ-022 err SHALL clear only on reset or on an accepted start.

Reset
REQ-023 While dsp_in_reset_reset=1 at a clock edge, the following SHALL hold on the next cycle: state IDLE, counter 0, all outputs 0, the start edge register loaded with the current sel_data[31] (no false start after reset).
REQ-024 Reset asserted mid-capture SHALL truncate the capture with no eop and no done.

Verification
REQ-025 Lane 3, cap_len=4, align=0, 4 continuous beats -> 4 beats with lane-3 data, 1 cycle latency, sop on beat 0, eop on beat 3, done 1 cycle later, busy low afterwards.
REQ-026 align=1, rfp in cycle T with sink_valid every cycle -> first captured beat is sink beat T+1; beat T is not output.
REQ-027 lane=9 with NUM_LANES=8, or cap_len=0 -> err=1, busy=0, no src_valid; a following valid start clears err.
REQ-028 continuous=1, align=1, cap_len=2, rfp every 10 cycles -> repeating sop/eop pairs, one pair per rfp, and no done.
REQ-029 Abort asserted on beat 2 of cap_len=8 -> IDLE next cycle, no eop, no done; a start on the following cycle is accepted.
REQ-030 sink_valid gapped 1-of-3 with cap_len=5 -> exactly 5 output beats with gaps preserved, eop on the 5th.

Source files
------------

// File: rtl/dxc_cap_sel_ctrl.sv
// Lane-select capture controller: picks one lane of a wide sample bus and
// forwards a counted burst of beats, optionally aligned to a radio-frame pulse.
module dxc_cap_sel_ctrl #(
  parameter int unsigned NUM_LANES = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CH_W      = 8,
  parameter int unsigned LEN_W     = 16
) (
  input  logic                        dsp_in_clk_clk,
  input  logic                        dsp_in_reset_reset,
  input  logic                        sink_valid,
  input  logic [CH_W-1:0]             sink_channel,
  input  logic [NUM_LANES*DATA_W-1:0] sink_data,
  input  logic                        rfp_pulse,
  input  logic [31:0]                 sel_data,
  input  logic [LEN_W-1:0]            cap_len,
  output logic                        src_valid,
  output logic [DATA_W-1:0]           src_data,
  output logic [CH_W-1:0]             src_channel,
  output logic [((NUM_LANES > 1) ? $clog2(NUM_LANES) : 1)-1:0] src_lane,
  output logic                        src_sop,
  output logic                        src_eop,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t            state_q, state_d;
  logic              start_prev_q;
  logic [LANE_W-1:0] lane_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              align_q;
  logic              cont_q;

  logic              start_edge_c;
  logic              abort_c;
  logic              cfg_ok_c;
  logic              beat_c;
  logic              last_c;
  logic              accept_c;
  logic              reject_c;
  logic [DATA_W-1:0] lane_data_c;

  // Control word bits [29:10] are reserved.
  logic unused_sel;
  assign unused_sel = ^sel_data[29:10];

  assign start_edge_c = sel_data[31] & ~start_prev_q;
  assign abort_c      = sel_data[30];
  assign cfg_ok_c     = ({24'd0, sel_data[7:0]} < NUM_LANES) && (cap_len != '0);
  assign beat_c       = (state_q == CAPTURE) && sink_valid && !abort_c;
  assign last_c       = beat_c && (cnt_q == len_q - LEN_W'(1));

  // Lane mux driven by the latched lane index only.
  always_comb begin
    lane_data_c = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (lane_q == LANE_W'(k)) lane_data_c = sink_data[k*DATA_W +: DATA_W];
    end
  end

  // Next-state logic; abort overrides everything including start and last beat.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    reject_c = 1'b0;
    if (abort_c) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_edge_c) begin
            if (cfg_ok_c) begin
              accept_c = 1'b1;
              state_d  = sel_data[8] ? ARMED : CAPTURE;
            end else begin
              reject_c = 1'b1;
            end
          end
        end
        ARMED: begin
          if (rfp_pulse) state_d = CAPTURE;
        end
        CAPTURE: begin
          if (last_c) begin
            if (!cont_q)     state_d = DONE;
            else if (align_q) state_d = ARMED;
            else              state_d = CAPTURE;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge dsp_in_clk_clk) begin
    if (dsp_in_reset_reset) begin
      state_q      <= IDLE;
      start_prev_q <= sel_data[31];
      lane_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      align_q      <= 1'b0;
      cont_q       <= 1'b0;
      src_valid    <= 1'b0;
      src_data     <= '0;
      src_channel  <= '0;
      src_lane     <= '0;
      src_sop      <= 1'b0;
      src_eop      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= sel_data[31];
      if (accept_c) begin
        lane_q  <= LANE_W'(sel_data[7:0]);
        len_q   <= cap_len;
        align_q <= sel_data[8];
        cont_q  <= sel_data[9];
        err     <= 1'b0;
      end else if (reject_c) begin
        err <= 1'b1;
      end
      if (abort_c || accept_c) cnt_q <= '0;
      else if (beat_c)         cnt_q <= last_c ? '0 : cnt_q + LEN_W'(1);
      src_valid <= beat_c;
      src_sop   <= beat_c && (cnt_q == '0);
      src_eop   <= last_c;
      if (beat_c) begin
        src_data    <= lane_data_c;
        src_channel <= sink_channel;
        src_lane    <= lane_q;
      end
      busy <= (state_d != IDLE);
      done <= (state_q == DONE) && !abort_c;
    end
  end

endmodule
